inta_sequencer: RTL

- CPU-side counterpart of the interrupt request register; completes the request path toward the processor.
- Resolves priority among pending unmasked requests against the in-service set (fully nested mode, IR0 highest) and drives INT.
- Runs the two-pulse INTA handshake and drives the 8-bit vector on the second pulse.
- Owns the in-service register (ISR) and returns one-cycle clear pulses to the request register.

---
 rtl/pic_pkg.sv | 20 ++
 rtl/priority_encoder8.sv | 17 +
 rtl/inta_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt acknowledge path.
// Levels are 3-bit indices; NO_LVL is the 4-bit "nothing in service" sentinel.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK1,
    WAIT_ACK2,
    DRIVE
  } state_t;

  localparam int         NUM_IR       = 8;
  localparam logic [2:0] SPURIOUS_LVL = 3'd7;
  localparam logic [3:0] NO_LVL       = 4'd8;

  function automatic logic [7:0] lvlMask(input logic [2:0] lvl);
    return 8'b1 << lvl;
  endfunction

endpackage

// File: rtl/priority_encoder8.sv
// Lowest-set-bit encoder: IR0 is the highest priority level.
module priority_encoder8 (
  input  logic [7:0] bits,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |bits;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// Priority resolution, INTA two-pulse handshake, vector drive and in-service register.
// The CPU request output is named cpuInt because "int" is a reserved word.
module inta_sequencer #(
  parameter bit AUTO_EOI = 1'b0,
  parameter int NUM_IR   = pic_pkg::NUM_IR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] interruptRequest,
  input  logic [NUM_IR-1:0] interruptMask,
  input  logic [4:0]        vectorBase,
  input  logic              intaN,
  input  logic              eoiStrobe,
  input  logic              eoiSpecific,
  input  logic [2:0]        eoiLevel,
  output logic              cpuInt,
  output logic [NUM_IR-1:0] clearInterruptRequest,
  output logic [NUM_IR-1:0] inServiceRegister,
  output logic [7:0]        dataOut,
  output logic              dataOutEnable
);
  import pic_pkg::*;

  state_t     state;
  logic       intaPrev;
  logic [2:0] ackLvl;
  logic       spurious;

  logic [7:0] pending;
  logic       pendValid, isrValid;
  logic [2:0] reqIdx, isrIdx;
  logic [3:0] isrLvl;
  logic       qualify, fallEdge, riseEdge;
  logic [7:0] ackSet, eoiClr, autoClr;

  assign pending = interruptRequest & ~interruptMask;

  priority_encoder8 uReqEnc (.bits(pending),           .valid(pendValid), .idx(reqIdx));
  priority_encoder8 uIsrEnc (.bits(inServiceRegister), .valid(isrValid),  .idx(isrIdx));

  // A request only interrupts if it outranks everything already in service.
  always_comb begin
    isrLvl   = isrValid ? {1'b0, isrIdx} : NO_LVL;
    qualify  = pendValid && ({1'b0, reqIdx} < isrLvl);
    fallEdge = intaPrev & ~intaN;
    riseEdge = ~intaPrev & intaN;

    ackSet = '0;
    if (state == WAIT_ACK1 && fallEdge && qualify) ackSet = lvlMask(reqIdx);

    eoiClr = '0;
    if (eoiStrobe) begin
      if (eoiSpecific)   eoiClr = lvlMask(eoiLevel);
      else if (isrValid) eoiClr = lvlMask(isrIdx);
    end

    autoClr = '0;
    if (AUTO_EOI && state == DRIVE && riseEdge && !spurious) autoClr = lvlMask(ackLvl);
  end

  // Sets are OR'd in after the clears so an ACK1 set beats a same-bit EOI.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      intaPrev              <= 1'b1;
      ackLvl                <= 3'd0;
      spurious              <= 1'b0;
      cpuInt                <= 1'b0;
      clearInterruptRequest <= '0;
      inServiceRegister     <= '0;
      dataOut               <= 8'd0;
      dataOutEnable         <= 1'b0;
    end else begin
      intaPrev              <= intaN;
      clearInterruptRequest <= '0;
      inServiceRegister     <= (inServiceRegister & ~eoiClr & ~autoClr) | ackSet;
      case (state)
        IDLE: begin
          cpuInt <= qualify;
          if (qualify) state <= WAIT_ACK1;
        end
        WAIT_ACK1: begin
          if (fallEdge) begin
            cpuInt <= 1'b0;
            state  <= WAIT_ACK2;
            if (qualify) begin
              ackLvl                <= reqIdx;
              spurious              <= 1'b0;
              clearInterruptRequest <= lvlMask(reqIdx);
            end else begin
              ackLvl   <= SPURIOUS_LVL;
              spurious <= 1'b1;
            end
          end else if (!qualify) begin
            cpuInt <= 1'b0;
            state  <= IDLE;
          end
        end
        WAIT_ACK2: begin
          if (fallEdge) begin
            dataOut       <= {vectorBase, ackLvl};
            dataOutEnable <= 1'b1;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          if (riseEdge) begin
            dataOutEnable <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
